// File: rtl/linear_proj_pkg.sv
// Shared sizing for the linear projection datapath and the matrix-C writer FSM states.
package linear_proj_pkg;

  // Matrix-C sizing for the projection instance
  localparam int NUM_CORES_A    = 1;
  localparam int NUM_CORES_B    = 1;
  localparam int TOTAL_MODULES  = 2;
  localparam int WIDTH_OUT      = 16;
  localparam int CHUNK_SIZE     = 4;
  localparam int TILE_LANES     = NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES;
  localparam int ROW_SIZE_MAT_C = 2;
  localparam int COL_SIZE_MAT_C = 3;

  localparam int DATA_WIDTH_C = WIDTH_OUT * CHUNK_SIZE * TILE_LANES;
  localparam int MAX_FLAG     = ROW_SIZE_MAT_C * COL_SIZE_MAT_C;
  localparam int ADDR_WIDTH_C = (MAX_FLAG > 1) ? $clog2(MAX_FLAG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } wr_state_e;

endpackage

// File: rtl/linear_proj_out_writer_if.sv
// Result-word input stream and memory write request channel of the matrix-C writer.
interface linear_proj_out_writer_if
  import linear_proj_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_C,
  parameter int ADDR_WIDTH = ADDR_WIDTH_C
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // master: matmul producer plus memory; slave: the writer itself
  modport master (
    output in_valid, in_data, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data
  );

endinterface

// File: rtl/linear_proj_out_writer.sv
// Writes one pass of column-major matrix-C result words to memory at row-major addresses
// through a single skid-free output register with full-throughput handshaking.
module linear_proj_out_writer
  import linear_proj_pkg::*;
#(
  parameter int WIDTH_OUT      = 16,
  parameter int CHUNK_SIZE     = 4,
  parameter int TILE_LANES     = 2,
  parameter int ROW_SIZE_MAT_C = 2,
  parameter int COL_SIZE_MAT_C = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  linear_proj_out_writer_if.slave  bus,
  output logic                     busy,
  output logic                     done
);

  localparam int DATA_WIDTH_C = WIDTH_OUT * CHUNK_SIZE * TILE_LANES;
  localparam int MAX_FLAG     = ROW_SIZE_MAT_C * COL_SIZE_MAT_C;
  localparam int ADDR_WIDTH_C = (MAX_FLAG > 1) ? $clog2(MAX_FLAG) : 1;
  localparam int ROW_W        = (ROW_SIZE_MAT_C > 1) ? $clog2(ROW_SIZE_MAT_C) : 1;
  localparam int COL_W        = (COL_SIZE_MAT_C > 1) ? $clog2(COL_SIZE_MAT_C) : 1;

  wr_state_e                 state_q, state_d;
  logic [ROW_W-1:0]          row_cnt_q, row_cnt_d;
  logic [COL_W-1:0]          col_cnt_q, col_cnt_d;
  logic                      wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH_C-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH_C-1:0]   wr_data_q, wr_data_d;

  logic out_free;
  logic in_ready_w;
  logic accept;
  logic last_word;

  // The output register can take a new word if it is empty or draining this cycle
  assign out_free   = !wr_valid_q || bus.wr_ready;
  assign in_ready_w = (state_q == RUN) && out_free;
  assign accept     = bus.in_valid && in_ready_w;
  assign last_word  = (row_cnt_q == ROW_W'(ROW_SIZE_MAT_C - 1)) &&
                      (col_cnt_q == COL_W'(COL_SIZE_MAT_C - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)                state_d = RUN;
      RUN:     if (accept && last_word)  state_d = DRAIN;
      DRAIN:   if (out_free)             state_d = DONE;
      DONE:                              state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Input is column-major, so the row index advances on every accept
  always_comb begin
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    if (state_q == IDLE && start) begin
      row_cnt_d = '0;
      col_cnt_d = '0;
    end else if (accept) begin
      if (row_cnt_q == ROW_W'(ROW_SIZE_MAT_C - 1)) begin
        row_cnt_d = '0;
        col_cnt_d = col_cnt_q + 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (accept) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = ADDR_WIDTH_C'(int'(row_cnt_q) * COL_SIZE_MAT_C + int'(col_cnt_q));
      wr_data_d  = bus.in_data;
    end else if (wr_valid_q && bus.wr_ready) begin
      wr_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  // NOTE: the wide data register is reset too, since wr_data must read 0
  // immediately on reset rather than holding a stale word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      col_cnt_q  <= col_cnt_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_linear_proj_out_writer.sv
// Directed bench for the matrix-C writer: 2x3 result words, backpressure, reset mid-pass.
module tb_linear_proj_out_writer;
  import linear_proj_pkg::*;

  localparam int DW = 128;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  linear_proj_out_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  linear_proj_out_writer #(
    .WIDTH_OUT     (16),
    .CHUNK_SIZE    (4),
    .TILE_LANES    (2),
    .ROW_SIZE_MAT_C(2),
    .COL_SIZE_MAT_C(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bus  (bus.slave),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;

  logic [AW-1:0] wa_log[$];
  logic [DW-1:0] wd_log[$];
  int            wc_log[$];
  int            ac_log[$];

  // Row-major addresses of column-major words D0..D5 for a 2x3 matrix
  logic [AW-1:0] exp_addr [6] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd2, 3'd5};

  function automatic logic [DW-1:0] word(input int i);
    logic [15:0] lane;
    lane = 16'(32'hD000 + i);
    return {8{lane}};
  endfunction

  // Record this cycle's handshakes, then advance to the next falling edge
  task automatic tick();
    #1;
    if (bus.in_valid && bus.in_ready) begin
      acc_cnt++;
      ac_log.push_back(cyc);
    end
    if (bus.wr_valid && bus.wr_ready) begin
      wa_log.push_back(bus.wr_addr);
      wd_log.push_back(bus.wr_data);
      wc_log.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    wa_log.delete();
    wd_log.delete();
    wc_log.delete();
    ac_log.delete();
    acc_cnt  = 0;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      got = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout: word %h not accepted within 20 cycles", d);
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      #1;
      if (done) seen = 1'b1;
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int first_data);
    checks++;
    if (wa_log.size() !== 6) begin
      errors++;
      $display("FAIL %s_write_count: got %0d want 6", tag, wa_log.size());
    end
    for (int i = 0; i < 6 && i < wa_log.size(); i++) begin
      checks++;
      if (wa_log[i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL %s_addr[%0d]: got %0d want %0d", tag, i, wa_log[i], exp_addr[i]);
      end
      checks++;
      if (wd_log[i] !== word(first_data + i)) begin
        errors++;
        $display("FAIL %s_data[%0d]: got %h want %h", tag, i, wd_log[i], word(first_data + i));
      end
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", bus.wr_valid); end
    checks++;
    if (bus.wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
    checks++;
    if (bus.wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++;
    if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_valid();
    clear_logs();
    bus.in_valid = 1'b1;
    bus.in_data  = word(9);
    repeat (3) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b want 0", bus.in_ready); end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc_cnt !== 0 || wa_log.size() !== 0) begin
      errors++;
      $display("FAIL idle_no_write: accepts %0d writes %0d want 0 0", acc_cnt, wa_log.size());
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    clear_logs();
    bus.wr_ready = 1'b1;
    start_pass();
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
    for (int i = 0; i < 6; i++) send(word(i));
    // A 7th word offered during drain, and start raised in the DONE cycle
    bus.in_valid = 1'b1;
    bus.in_data  = word(6);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (done) begin
        seen  = 1'b1;
        start = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_done_timeout: no done within 10 cycles"); end
    #1;
    checks++;
    if (busy !== 1'b0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL b2b_start_in_done: busy %b state %0d want 0 IDLE", busy, dut.state_q);
    end
    tick();
    tick();
    checks++;
    if (acc_cnt !== 6) begin errors++; $display("FAIL b2b_accepts: got %0d want 6", acc_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt); end
    if (ac_log.size() == 6) begin
      checks++;
      if (done_cyc !== ac_log[5] + 2) begin
        errors++;
        $display("FAIL b2b_done_latency: got cycle %0d want %0d", done_cyc, ac_log[5] + 2);
      end
      for (int i = 0; i < 6 && i < wc_log.size(); i++) begin
        checks++;
        if (wc_log[i] !== ac_log[0] + 1 + i) begin
          errors++;
          $display("FAIL b2b_write_cycle[%0d]: got %0d want %0d", i, wc_log[i], ac_log[0] + 1 + i);
        end
      end
    end
    check_writes("b2b", 0);
  endtask

  task automatic test_backpressure();
    clear_logs();
    bus.wr_ready = 1'b1;
    start_pass();
    for (int i = 0; i < 3; i++) send(word(i));
    bus.wr_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = word(3);
    repeat (3) begin
      #1;
      checks++;
      if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 3'd1 || bus.wr_data !== word(2)) begin
        errors++;
        $display("FAIL stall_hold: valid %b addr %0d data %h want 1 1 %h",
                 bus.wr_valid, bus.wr_addr, bus.wr_data, word(2));
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
      tick();
    end
    bus.wr_ready = 1'b1;
    for (int i = 3; i < 6; i++) send(word(i));
    wait_done(10);
    checks++;
    if (acc_cnt !== 6 || done_cnt !== 1) begin
      errors++;
      $display("FAIL stall_counts: accepts %0d done %0d want 6 1", acc_cnt, done_cnt);
    end
    check_writes("stall", 0);
  endtask

  task automatic test_start_ignored();
    clear_logs();
    bus.wr_ready = 1'b1;
    start_pass();
    send(word(10));
    send(word(11));
    start = 1'b1;
    send(word(12));
    start = 1'b0;
    for (int i = 13; i < 16; i++) send(word(i));
    wait_done(10);
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
    check_writes("restart", 10);
  endtask

  task automatic test_reset_mid_pass();
    clear_logs();
    bus.wr_ready = 1'b1;
    start_pass();
    for (int i = 0; i < 4; i++) send(word(20 + i));
    bus.wr_ready = 1'b0;
    #1;
    checks++;
    if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 3'd4) begin
      errors++;
      $display("FAIL midrst_pending: valid %b addr %0d want 1 4", bus.wr_valid, bus.wr_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wr_valid !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: valid %b addr %0d data %h want 0 0 0",
               bus.wr_valid, bus.wr_addr, bus.wr_data);
    end
    checks++;
    if (dut.state_q !== IDLE || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: state %0d busy %b in_ready %b want IDLE 0 0",
               dut.state_q, busy, bus.in_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    bus.wr_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
    checks++;
    if (wa_log.size() !== 3) begin errors++; $display("FAIL midrst_dropped: writes %0d want 3", wa_log.size()); end
    clear_logs();
    start_pass();
    send(word(30));
    tick();
    checks++;
    if (wa_log.size() < 1) begin
      errors++;
      $display("FAIL midrst_restart_write: got 0 writes want 1");
    end else if (wa_log[0] !== 3'd0 || wd_log[0] !== word(30)) begin
      errors++;
      $display("FAIL midrst_restart_write: addr %0d data %h want 0 %h", wa_log[0], wd_log[0], word(30));
    end
  endtask

  initial begin
    test_reset();
    test_idle_valid();
    test_back_to_back();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_pass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
